// File: rtl/vpi_bit_packer.sv
// Serial-to-parallel capture of the upstream x stream: LSB-first packing into
// WIDTH-bit words, queued in a DEPTH-entry FIFO with drop/overflow accounting.
module vpi_bit_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x,
    input  logic                       x_en,
    output logic                       word_valid,
    output logic [WIDTH-1:0]           word_data,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic [7:0]                 drop_cnt,
    output logic                       overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             complete;
    logic [WIDTH-1:0] word;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign complete = x_en && (bit_cnt == BW'(WIDTH - 1));
    assign word     = {x, sh};
    assign pop      = word_valid && word_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok  = complete && ((fifo_cnt < CW'(DEPTH)) || pop);
    assign drop     = complete && !push_ok;

    assign word_valid = (fifo_cnt != '0);
    // Gated so stale or uninitialised storage never shows on the output.
    assign word_data  = word_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (x_en) begin
            if (complete) begin
                sh      <= '0;
                bit_cnt <= '0;
            end else begin
                for (int i = 0; i < WIDTH - 1; i++) begin
                    if (bit_cnt == BW'(i)) sh[i] <= x;
                end
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vpi_bit_packer.sv
// Directed bench for vpi_bit_packer: packing, gaps, overflow, full+pop,
// mid-word reset and drop counter saturation.
module tb_vpi_bit_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       x_en = 1'b0;
    logic       word_ready = 1'b0;
    logic       word_valid;
    logic [7:0] word_data;
    logic [2:0] bit_cnt;
    logic [2:0] fifo_cnt;
    logic [7:0] drop_cnt;
    logic       overflow;

    int n_checks = 0;
    int n_fail = 0;

    vpi_bit_packer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .x_en       (x_en),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt),
        .fifo_cnt   (fifo_cnt),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        x    = b;
        x_en = 1'b1;
        tick();
        x_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);

        // Basic word 1,0,1,1,0,0,1,0 -> 8'h4D
        v = 8'h4D;
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        chk("t1_bitcnt7", bit_cnt, 7);
        chk("t1_novalid_yet", word_valid, 0);
        send_bit(v[7]);
        chk("t1_valid", word_valid, 1);
        chk("t1_data", word_data, 8'h4D);
        chk("t1_fifo_cnt", fifo_cnt, 1);
        chk("t1_bit_cnt", bit_cnt, 0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t1_popped", word_valid, 0);
        chk("t1_empty", fifo_cnt, 0);

        // Gapped enable: 3 bits, 5 idle cycles, 5 bits
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t2_gap_bitcnt", bit_cnt, 3);
        chk("t2_gap_novalid", word_valid, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t2_fifo_cnt", fifo_cnt, 1);
        chk("t2_data", word_data, 8'hFF);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t2_empty", fifo_cnt, 0);

        // Overflow: 5 words into a 4-deep FIFO
        for (int k = 1; k <= 4; k++) send_word(8'(k));
        chk("t3_full", fifo_cnt, 4);
        chk("t3_no_drop_yet", drop_cnt, 0);
        send_word(8'h05);
        chk("t3_full_after", fifo_cnt, 4);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_ovf", overflow, 1);
        word_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t3_drain%0d", k), word_data, k);
            tick();
        end
        word_ready = 1'b0;
        chk("t3_drained", word_valid, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Full FIFO with pop on the edge the 5th word completes
        do_reset();
        chk("t4_ovf_cleared", overflow, 0);
        for (int k = 0; k < 4; k++) send_word(8'h11 + 8'(k));
        chk("t4_full", fifo_cnt, 4);
        v = 8'h15;
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        word_ready = 1'b1;
        send_bit(v[7]);
        word_ready = 1'b0;
        chk("t4_fifo_cnt", fifo_cnt, 4);
        chk("t4_drop", drop_cnt, 0);
        chk("t4_ovf", overflow, 0);
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_drain%0d", k), word_data, 8'h12 + 8'(k));
            tick();
        end
        word_ready = 1'b0;
        chk("t4_drained", fifo_cnt, 0);

        // Reset mid-word with 2 words queued
        send_word(8'hA5);
        send_word(8'h3C);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t5_pre_fifo", fifo_cnt, 2);
        chk("t5_pre_bitcnt", bit_cnt, 4);
        do_reset();
        chk("t5_bit_cnt", bit_cnt, 0);
        chk("t5_fifo_cnt", fifo_cnt, 0);
        chk("t5_valid", word_valid, 0);
        chk("t5_data", word_data, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t5_no_early_word", fifo_cnt, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t5_fifo_one", fifo_cnt, 1);
        chk("t5_data_ff", word_data, 8'hFF);

        // Drop counter saturation
        do_reset();
        for (int k = 0; k < 4; k++) send_word(8'(k));
        for (int k = 0; k < 254; k++) send_word(8'hEE);
        chk("t6_drop254", drop_cnt, 254);
        send_word(8'hEE);
        chk("t6_drop255", drop_cnt, 255);
        for (int k = 0; k < 45; k++) send_word(8'hEE);
        chk("t6_drop_sat", drop_cnt, 255);
        chk("t6_ovf", overflow, 1);
        chk("t6_fifo_cnt", fifo_cnt, 4);
        chk("t6_hier_drop", dut.drop_cnt, 255);
        chk("t6_hier_fifo", dut.fifo_cnt, 4);
        chk("t6_head", word_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vpi_bit_packer.md
# vpi_bit_packer

Downstream capture stage for the serial `x` output of the registered AND stage in the VPI module test hierarchy. Collects enabled `x` samples LSB-first into WIDTH-bit words and queues them in a small FIFO. The FIFO feeds a valid/ready consumer. Public counters and flags let the VPI C harness inspect progress and overflow by hierarchical name.

## Interface
- WIDTH, 8: bits per packed word; must be ≥ 2.
- DEPTH, 4: FIFO entries; power of 2, ≥ 2.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- x  in  1  serial data bit from the upstream registered stage.
- x_en  in  1  sample enable; `x` is captured on posedge when high.
- word_valid  out  1  FIFO head holds a word.
- word_data  out  WIDTH  FIFO head word; bit 0 is the earliest sample.
- word_ready  in  1  consumer accepts the head word.
- bit_cnt  out  clog2(WIDTH)  bits held in the partial word; public_flat_rw.
- fifo_cnt  out  clog2(DEPTH)+1  FIFO occupancy; public_flat_rw.
- drop_cnt  out  8  words dropped on overflow; saturates at 255; public_flat_rw.
- overflow  out  1  sticky; set on the first drop, cleared only by rst; public_flat_rw.

## Operation
- Shift register `sh[WIDTH-2:0]` plus `bit_cnt`.
- On x_en with bit_cnt < WIDTH-1:
  - sh[bit_cnt] <= x
  - bit_cnt increments.
- On x_en with bit_cnt == WIDTH-1, the word completes:
  - word = {x, sh}
  - bit_cnt wraps to 0.
  - A push is requested in the same cycle.
- Push handling:
  - Accepted if fifo_cnt < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is discarded, drop_cnt increments (saturating) and overflow is set.
  - The partial-word state resets regardless of acceptance.
- Pop: word_valid && word_ready. The head advances.
- Simultaneous push and pop:
  - fifo_cnt is unchanged.
  - When full, the push is accepted because the pop frees the slot.
  - When empty, no pop is possible because word_valid is 0.
- Pointers:
  - wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
  - fifo_cnt is tracked separately, with range 0..DEPTH.
- word_valid = (fifo_cnt != 0).
- word_data = mem[rd_ptr]. Registered storage, no fall-through.
- word_ready while word_valid is low has no effect.
- Reset values: bit_cnt=0, sh=0, fifo_cnt=0, word_valid=0, drop_cnt=0, overflow=0, both pointers 0. FIFO memory is not cleared.
- word_data is 0 after reset until the first push. Gate the output with fifo_cnt != 0, or clear mem[0].
- A reset in mid-word or mid-queue discards the partial word and all queued words. There is no push at the reset edge.

## Timing
- Latency: word_valid rises on the cycle after the posedge that sampled the WIDTH-th bit.
- Back-to-back x_en every cycle gives one word per WIDTH cycles.
- With word_ready held high, the FIFO never exceeds 1 entry.
- A pop on edge N makes the next head visible after edge N. Sustained 1 word/cycle drain is possible.
- drop_cnt and overflow update on the same edge as the rejected push.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Test plan
- Reset then 8 x_en cycles with x = 1,0,1,1,0,0,1,0 → word_valid=1 one cycle later, word_data=8'h4D, fifo_cnt=1, bit_cnt=0.
- x_en toggled with gaps: 3 bits, 5 idle cycles, 5 more bits (all 1) → exactly one word 8'hFF. bit_cnt holds at 3 during the gap.
- word_ready=0, 5 full words pushed (values 8'h01..8'h05) → fifo_cnt=4, word 8'h05 dropped, drop_cnt=1, overflow=1. Then drain → 01,02,03,04 in order.
- FIFO full and word_ready=1 on the same edge a 5th word completes → no drop, fifo_cnt stays 4, overflow stays 0.
- rst asserted after 4 bits of a word with 2 words queued → next cycle all counters 0, word_valid=0. A subsequent 8 bits of 1 yields 8'hFF, proving no stale bits remain.
- 300 dropped words with word_ready=0 → drop_cnt saturates at 255, overflow=1. VPI reads of drop_cnt and fifo_cnt match the port values.
